// File: rtl/id_scoreboard_issue_if.sv
// id_scoreboard_issue_if: fetch/decode/execute/writeback signals around the ID stage.
interface id_scoreboard_issue_if #(
    parameter int ADDR_W = 5,
    parameter int BUS_W  = 64
);
    logic              fs_to_ds_valid;
    logic [BUS_W-1:0]  fs_to_ds_bus;
    logic              ds_allowin;
    logic              ds_src1_en;
    logic [ADDR_W-1:0] ds_src1;
    logic              ds_src2_en;
    logic [ADDR_W-1:0] ds_src2;
    logic              ds_dest_we;
    logic [ADDR_W-1:0] ds_dest;
    logic [BUS_W-1:0]  ds_inst_bus;
    logic              es_allowin;
    logic              ds_to_es_valid;
    logic [BUS_W-1:0]  ds_to_es_bus;
    logic              ws_retire_valid;
    logic [ADDR_W-1:0] ws_retire_dest;
    logic              flush;
    logic              ds_stall;

    modport slave (
        input  fs_to_ds_valid, fs_to_ds_bus, ds_src1_en, ds_src1, ds_src2_en, ds_src2,
               ds_dest_we, ds_dest, es_allowin, ws_retire_valid, ws_retire_dest, flush,
        output ds_allowin, ds_inst_bus, ds_to_es_valid, ds_to_es_bus, ds_stall
    );

    modport master (
        output fs_to_ds_valid, fs_to_ds_bus, ds_src1_en, ds_src1, ds_src2_en, ds_src2,
               ds_dest_we, ds_dest, es_allowin, ws_retire_valid, ws_retire_dest, flush,
        input  ds_allowin, ds_inst_bus, ds_to_es_valid, ds_to_es_bus, ds_stall
    );
endinterface

// File: rtl/id_scoreboard_issue.sv
// id_scoreboard_issue: ID pipeline latch with per-GPR pending-write scoreboard driving issue.
// Define ID_RETIRE_BYPASS_EN to let a dependent instruction issue in its producer's retire cycle.
module id_scoreboard_issue #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int BUS_W   = 64,
    parameter int CNT_W   = 2
) (
    input logic clk,
    input logic resetn,
    id_scoreboard_issue_if.slave ds
);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;

    logic             ds_valid_q, ds_valid_d;
    logic [BUS_W-1:0] bus_q;
    cnt_t             cnt_q [REG_NUM];
    cnt_t             cnt_d [REG_NUM];
    cnt_t             c1, c2, cd, cr;
    logic             byp1, byp2, hz1, hz2, waw_sat, ready_go, issue, underflow;

    function automatic logic tracked(input logic [ADDR_W-1:0] a);
        return a != '0 && 32'(a) < REG_NUM;
    endfunction

    // Untracked addresses (r0 and out-of-range) read as never pending.
    assign c1 = tracked(ds.ds_src1) ? cnt_q[ds.ds_src1] : '0;
    assign c2 = tracked(ds.ds_src2) ? cnt_q[ds.ds_src2] : '0;
    assign cd = tracked(ds.ds_dest) ? cnt_q[ds.ds_dest] : '0;
    assign cr = tracked(ds.ws_retire_dest) ? cnt_q[ds.ws_retire_dest] : '0;

`ifdef ID_RETIRE_BYPASS_EN
    // The last pending write retiring now reaches the operand through the regfile write-through.
    assign byp1 = ds.ws_retire_valid && ds.ws_retire_dest == ds.ds_src1 && c1 == cnt_t'(1);
    assign byp2 = ds.ws_retire_valid && ds.ws_retire_dest == ds.ds_src2 && c2 == cnt_t'(1);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign hz1      = ds.ds_src1_en && c1 != '0 && !byp1;
    assign hz2      = ds.ds_src2_en && c2 != '0 && !byp2;
    assign waw_sat  = ds.ds_dest_we && cd == CNT_MAX;
    assign ready_go = !hz1 && !hz2 && !waw_sat;

    assign ds.ds_allowin     = !ds_valid_q || (ready_go && ds.es_allowin);
    assign ds.ds_to_es_valid = ds_valid_q && ready_go && !ds.flush;
    assign ds.ds_stall       = ds_valid_q && !ready_go;
    assign ds.ds_inst_bus    = bus_q;
    assign ds.ds_to_es_bus   = bus_q;
    assign issue             = ds.ds_to_es_valid && ds.es_allowin;
    assign ds_valid_d        = ds.flush ? 1'b0 : ds.ds_allowin ? ds.fs_to_ds_valid : ds_valid_q;

    // Same-cycle issue and retire of one register cancel; a retire at zero holds zero.
    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            logic inc, dec;
            inc      = r != 0 && issue && ds.ds_dest_we && 32'(ds.ds_dest) == r;
            dec      = r != 0 && ds.ws_retire_valid && 32'(ds.ws_retire_dest) == r;
            cnt_d[r] = (inc && !dec) ? cnt_q[r] + cnt_t'(1) :
                       (dec && !inc && cnt_q[r] != '0) ? cnt_q[r] - cnt_t'(1) : cnt_q[r];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid_q <= 1'b0;
            for (int r = 0; r < REG_NUM; r++) cnt_q[r] <= '0;
        end else begin
            ds_valid_q <= ds_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ds.fs_to_ds_valid && ds.ds_allowin) bus_q <= ds.fs_to_ds_bus;
    end

    assign underflow = ds.ws_retire_valid && tracked(ds.ws_retire_dest) && cr == '0;

    assert property (@(posedge clk) disable iff (!resetn) !underflow)
        else $error("id_scoreboard_issue: retire of r%0d with no pending write", ds.ws_retire_dest);
endmodule

// File: tb/tb_id_scoreboard_issue.sv
// tb_id_scoreboard_issue: per-cycle vector table for id_scoreboard_issue plus an async-reset sequence.
module tb_id_scoreboard_issue;
    localparam logic [63:0] P1  = 64'h00400000_24020005;
    localparam logic [63:0] P2  = 64'h00400004_00421821;
    localparam logic [63:0] W1  = 64'h00400010_00000051;
    localparam logic [63:0] W2  = 64'h00400014_00000052;
    localparam logic [63:0] W3  = 64'h00400018_00000053;
    localparam logic [63:0] W4  = 64'h0040001c_00000054;
    localparam logic [63:0] A7A = 64'h00400020_00000071;
    localparam logic [63:0] A7B = 64'h00400024_00000072;
    localparam logic [63:0] C4  = 64'h00400028_00000041;
    localparam logic [63:0] DD  = 64'h0040002c_000000d6;
    localparam logic [63:0] EE  = 64'h00400030_000000e8;
    localparam logic [63:0] FF  = 64'h00400034_000000f4;
    localparam logic [63:0] GG  = 64'h00400038_000000a4;
`ifdef ID_RETIRE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct {
        logic fv; logic [63:0] bus;
        logic s1e; logic [4:0] s1; logic s2e; logic [4:0] s2; logic dwe; logic [4:0] dst;
        logic ea; logic rv; logic [4:0] rd; logic fl;
        logic e_al; logic e_vl; logic e_st; logic [63:0] e_bus;
        int ck_r; int ck_c;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    id_scoreboard_issue_if #(.ADDR_W(5), .BUS_W(64)) bus_if ();

    id_scoreboard_issue #(.REG_NUM(32), .ADDR_W(5), .BUS_W(64), .CNT_W(2)) dut (
        .clk(clk),
        .resetn(resetn),
        .ds(bus_if)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic fv, input logic [63:0] bus, input logic s1e, input logic [4:0] s1,
                       input logic s2e, input logic [4:0] s2, input logic dwe, input logic [4:0] dst,
                       input logic ea, input logic rv, input logic [4:0] rd, input logic fl,
                       input logic al, input logic vl, input logic st, input logic [63:0] eb,
                       input int ckr, input int ckc);
        vec_t v;
        v = '{fv, bus, s1e, s1, s2e, s2, dwe, dst, ea, rv, rd, fl, al, vl, st, eb, ckr, ckc};
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        bus_if.fs_to_ds_valid  = v.fv;
        bus_if.fs_to_ds_bus    = v.bus;
        bus_if.ds_src1_en      = v.s1e;
        bus_if.ds_src1         = v.s1;
        bus_if.ds_src2_en      = v.s2e;
        bus_if.ds_src2         = v.s2;
        bus_if.ds_dest_we      = v.dwe;
        bus_if.ds_dest         = v.dst;
        bus_if.es_allowin      = v.ea;
        bus_if.ws_retire_valid = v.rv;
        bus_if.ws_retire_dest  = v.rd;
        bus_if.flush           = v.fl;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " allowin"}, 64'(bus_if.ds_allowin), 64'd1);
        chk({tag, " to_es_valid"}, 64'(bus_if.ds_to_es_valid), 64'd0);
        chk({tag, " stall"}, 64'(bus_if.ds_stall), 64'd0);
    endtask

    initial begin
        // addiu r2 issue, RAW on r2
        add(1, P1, 0,0,0,0, 0,0, 1, 0,0, 0, 1,0,0, 0,  -1,0);
        add(1, P2, 1,0,0,0, 1,2, 1, 0,0, 0, 1,1,0, P1,  2,0);
        add(0, 0,  1,2,1,2, 1,3, 1, 0,0, 0, 0,0,1, P2,  2,1);
        add(0, 0,  1,2,1,2, 1,3, 1, 0,0, 0, 0,0,1, P2, -1,0);
        add(0, 0,  1,2,1,2, 1,3, 1, 1,2, 0, BYP,BYP,!BYP, P2, 2,1);
        add(0, 0,  1,2,1,2, 1,3, 1, 0,0, 0, 1,!BYP,0, P2, 2,0);
        add(0, 0,  0,0,0,0, 0,0, 1, 1,3, 0, 1,0,0, 0,   3,1);
        // three writers of r5 saturate, fourth waits for a retire
        add(1, W1, 0,0,0,0, 0,0, 1, 0,0, 0, 1,0,0, 0,   3,0);
        add(1, W2, 0,0,0,0, 1,5, 1, 0,0, 0, 1,1,0, W1,  5,0);
        add(1, W3, 0,0,0,0, 1,5, 1, 0,0, 0, 1,1,0, W2,  5,1);
        add(1, W4, 0,0,0,0, 1,5, 1, 0,0, 0, 1,1,0, W3,  5,2);
        add(0, 0,  0,0,0,0, 1,5, 1, 0,0, 0, 0,0,1, W4,  5,3);
        add(0, 0,  0,0,0,0, 1,5, 1, 0,0, 0, 0,0,1, W4, -1,0);
        add(0, 0,  0,0,0,0, 1,5, 1, 1,5, 0, 0,0,1, W4,  5,3);
        add(0, 0,  0,0,0,0, 1,5, 0, 0,0, 0, 0,1,0, W4,  5,2);
        add(0, 0,  0,0,0,0, 1,5, 1, 0,0, 0, 1,1,0, W4,  5,2);
        add(0, 0,  0,0,0,0, 0,0, 1, 1,5, 0, 1,0,0, 0,   5,3);
        add(0, 0,  0,0,0,0, 0,0, 1, 1,5, 0, 1,0,0, 0,   5,2);
        add(0, 0,  0,0,0,0, 0,0, 1, 1,5, 0, 1,0,0, 0,   5,1);
        // issue and retire of r7 in the same cycle
        add(1, A7A,0,0,0,0, 0,0, 1, 0,0, 0, 1,0,0, 0,   5,0);
        add(1, A7B,0,0,0,0, 1,7, 1, 0,0, 0, 1,1,0, A7A, 7,0);
        add(0, 0,  0,0,0,0, 1,7, 1, 1,7, 0, 1,1,0, A7B, 7,1);
        add(0, 0,  0,0,0,0, 0,0, 1, 1,7, 0, 1,0,0, 0,   7,1);
        // flush of a stalled and of a ready instruction
        add(1, C4, 0,0,0,0, 0,0, 1, 0,0, 0, 1,0,0, 0,   7,0);
        add(1, DD, 0,0,0,0, 1,4, 1, 0,0, 0, 1,1,0, C4,  4,0);
        add(0, 0,  1,4,0,0, 1,6, 1, 0,0, 0, 0,0,1, DD,  4,1);
        add(0, 0,  1,4,0,0, 1,6, 1, 0,0, 1, 0,0,1, DD,  4,1);
        add(1, EE, 1,4,0,0, 1,6, 1, 0,0, 0, 1,0,0, 0,   4,1);
        add(0, 0,  0,0,0,0, 1,8, 1, 0,0, 1, 1,0,0, EE,  6,0);
        add(0, 0,  0,0,0,0, 1,8, 1, 0,0, 0, 1,0,0, 0,   8,0);
        // build cnt[4]=2 with a dependent stalled in ID
        add(1, FF, 0,0,0,0, 0,0, 1, 0,0, 0, 1,0,0, 0,   4,1);
        add(1, GG, 0,0,0,0, 1,4, 1, 0,0, 0, 1,1,0, FF,  4,1);
        add(0, 0,  1,4,0,0, 0,0, 1, 0,0, 0, 0,0,1, GG,  4,2);

        resetn = 1'b0;
        apply('{0, 0, 0,0,0,0, 0,0, 1, 0,0, 0, 1,0,0, 0, -1,0});
        repeat (2) @(negedge clk);
        #1;
        chk_idle("reset");
        chk("reset cnt2", 64'(dut.cnt_q[2]), 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            chk($sformatf("row%0d allowin", i), 64'(bus_if.ds_allowin), 64'(tbl[i].e_al));
            chk($sformatf("row%0d to_es_valid", i), 64'(bus_if.ds_to_es_valid), 64'(tbl[i].e_vl));
            chk($sformatf("row%0d stall", i), 64'(bus_if.ds_stall), 64'(tbl[i].e_st));
            if (tbl[i].e_bus != 64'd0) begin
                chk($sformatf("row%0d to_es_bus", i), bus_if.ds_to_es_bus, tbl[i].e_bus);
                chk($sformatf("row%0d inst_bus", i), bus_if.ds_inst_bus, tbl[i].e_bus);
            end
            if (tbl[i].ck_r >= 0)
                chk($sformatf("row%0d cnt%0d", i, tbl[i].ck_r), 64'(dut.cnt_q[tbl[i].ck_r]), 64'(tbl[i].ck_c));
        end

        // asynchronous reset in the middle of the r4 stall
        #2 resetn = 1'b0;
        #1;
        chk_idle("async_reset");
        chk("async_reset cnt4", 64'(dut.cnt_q[4]), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk_idle("post_reset");
        chk("post_reset cnt4", 64'(dut.cnt_q[4]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_scoreboard_issue.md
Name: id_scoreboard_issue

Overview:
Parametrised successor to the decode-stage pipeline latch and issue control. It holds one decoded instruction between fetch and execute, and keeps a per-register pending-write scoreboard. ds_ready_go is derived from RAW/WAW hazards instead of an externally driven stall code. It sits between fs and es in the 5-stage core, and takes retire notifications from ws.

Parameters:
REG_NUM, 32, number of architectural GPRs tracked (register 0 is never tracked)
ADDR_W, 5, register address width; must be at least clog2(REG_NUM)
BUS_W, 64, width of the opaque fs_to_ds payload
CNT_W, 2, per-register pending counter width; max in-flight writes per register = 2^CNT_W-1

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
fs_to_ds_valid  in  1  fetch stage holds a valid instruction
fs_to_ds_bus  in  BUS_W  fetch payload (inst, pc)
ds_allowin  out  1  ID can accept a new instruction this cycle
ds_src1_en  in  1  current ID instruction reads src1 (combinational from external decoder)
ds_src1  in  ADDR_W  src1 register address
ds_src2_en  in  1  current ID instruction reads src2
ds_src2  in  ADDR_W  src2 register address
ds_dest_we  in  1  current ID instruction writes a GPR
ds_dest  in  ADDR_W  destination register address
ds_inst_bus  out  BUS_W  latched payload, drives the external decoder
es_allowin  in  1  execute stage accepts
ds_to_es_valid  out  1  issue request
ds_to_es_bus  out  BUS_W  latched payload forwarded to es
ws_retire_valid  in  1  writeback commits a GPR write this cycle
ws_retire_dest  in  ADDR_W  committed destination
flush  in  1  kill the instruction in ID (branch redirect/exception)
ds_stall  out  1  ds_valid && !ds_ready_go, for perf counters

Behaviour:
- Reset (asynchronous, resetn=0): ds_valid=0 and all scoreboard counters=0. While in reset, ds_to_es_valid=0, ds_stall=0 and ds_allowin=1. Bus registers are not reset.
- ds_inst_bus = ds_to_es_bus = latched payload, with zero added latency.
- Handshake:
  - ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
  - ds_to_es_valid = ds_valid && ds_ready_go && !flush.
  - Issue event = ds_to_es_valid && es_allowin.
- Latch: when ds_allowin, ds_valid <= fs_to_ds_valid && !flush. When fs_to_ds_valid && ds_allowin, the bus is captured.
- Flush has priority: ds_valid <= 0 next cycle, and the held instruction produces no issue event.
- ds_ready_go = !hz1 && !hz2 && !waw_sat.
  - hzN = srcN_en && srcN!=0 && cnt[srcN]!=0.
  - waw_sat = dest_we && dest!=0 && cnt[dest]==max.
- Scoreboard counters:
  - Increment cnt[ds_dest] on an issue event with ds_dest_we && ds_dest!=0.
  - Decrement cnt[ws_retire_dest] on ws_retire_valid && ws_retire_dest!=0.
  - Increment and decrement of the same register in the same cycle leave the counter unchanged.
  - Decrement at 0 is illegal. The counter holds 0; in simulation, $display an error.
  - Addresses >= REG_NUM are ignored.
- Flush does not clear the scoreboard. Already-issued instructions still retire.
- Register 0 is never pending.
- Source equal to dest (e.g. addiu r3,r3,1): the hazard is checked on the old count only.

Optional Feature:
Macro ID_RETIRE_BYPASS_EN.
- Defined: a source is not hazardous if ws_retire_valid && ws_retire_dest==srcN && cnt[srcN]==1. The regfile write-through supplies the value, and the dependent instruction issues in the retire cycle.
- Undefined: the dependent instruction issues the cycle after the counter reaches 0, which costs one extra stall cycle.

Test Plan:
- Reset release, fs_to_ds_valid=1 with payload 0x00400000_24020005, es_allowin=1 → ds_to_es_valid=1 on the next cycle with the same payload, and cnt[2]=1 after issue.
- addiu r2 issued, then addu r3,r2,r2 in ID → ds_stall=1 and ds_allowin=0 until ws_retire_valid with dest 2. Issue happens in the retire cycle if ID_RETIRE_BYPASS_EN is defined, otherwise one cycle later.
- Three issues writing r5 with CNT_W=2 → cnt[5]=3. A fourth writer of r5 stalls (waw_sat) until one retire.
- Simultaneous issue writing r7 and retire of r7 with cnt[7]=1 → cnt[7] stays 1.
- flush asserted while a stalled instruction is held → ds_to_es_valid=0 that cycle, ds_valid=0 next cycle, and the scoreboard is unchanged.
- resetn pulled low mid-stall with cnt[4]=2 → all outputs return to reset values immediately and cnt[4]=0.
